// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter register and redirect/flush controller.
// A RUN/FLUSH state machine owns the fetch PC. A taken branch or a jump in EX
// loads the target and raises flush for FLUSH_CYCLES unstalled cycles.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a misaligned
// redirect goes to TRAP_VEC and latches the offending address. When it is not
// defined, the low target bits are cleared and the trap outputs are tied low.
module pc_gen #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_sel,
    input  logic        jump,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        misalign_trap,
    output logic [31:0] bad_addr
);

    typedef enum logic {RUN, FLUSH} state_e;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        req;
    logic [31:0] redirect_pc;
    logic        misaligned;

    assign req      = branch_sel | jump;
    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign flush    = flush_q;

`ifdef MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic [31:0] bad_q, bad_d;

    assign misaligned    = |target[1:0];
    assign redirect_pc   = misaligned ? TRAP_VEC : {target[31:2], 2'b00};
    assign misalign_trap = trap_q;
    assign bad_addr      = bad_q;

    // Trap pulse and offending address; the pulse clears on the following edge.
    always_comb begin
        trap_d = 1'b0;
        bad_d  = bad_q;
        if (state_q == RUN && req && misaligned) begin
            trap_d = 1'b1;
            bad_d  = target;
        end
    end

    // Trap status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_q <= 1'b0;
            bad_q  <= 32'h0000_0000;
        end else begin
            trap_q <= trap_d;
            bad_q  <= bad_d;
        end
    end
`else
    logic unused_cfg;

    assign misaligned    = 1'b0;
    assign redirect_pc   = {target[31:2], 2'b00};
    assign misalign_trap = 1'b0;
    assign bad_addr      = 32'h0000_0000;
    assign unused_cfg    = ^{TRAP_VEC, target[1:0], misaligned};
`endif

    // Next-state logic. In FLUSH, redirect requests come from squashed
    // instructions and are ignored. The counter only moves on unstalled cycles.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        case (state_q)
            RUN: begin
                if (req) begin
                    pc_d    = redirect_pc;
                    cnt_d   = FLUSH_INIT;
                    flush_d = 1'b1;
                    state_d = FLUSH;
                end else if (!stall) begin
                    pc_d = pc_plus4;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    pc_d = pc_plus4;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        flush_d = 1'b0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                flush_d = 1'b0;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State, PC, flush counter and flush registers. An asynchronous reset
    // aborts any flush sequence that is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= 3'd0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen. The expected values are computed by hand
// from the redirect, flush and wrap rules.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_sel;
    logic        jump;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        misalign_trap;
    logic [31:0] bad_addr;

    int n_checks = 0;
    int n_fail   = 0;

    pc_gen #(
        .RESET_PC    (32'h0000_0000),
        .FLUSH_CYCLES(2),
        .TRAP_VEC    (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_sel   (branch_sel),
        .jump         (jump),
        .target       (target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .flush        (flush),
        .misalign_trap(misalign_trap),
        .bad_addr     (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pf(input string tag, input logic [31:0] epc, input logic ef);
        check({tag, ".pc"}, pc, epc);
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, ef});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_sel = 1'b0; jump = 1'b0; target = 32'h0;
        #3;
        expect_pf("reset", 32'h0, 1'b0);
        check("reset.trap", {31'd0, misalign_trap}, 32'd0);
        check("reset.bad", bad_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_pf("rel", 32'h0, 1'b0);
        check("rel.pc4", pc_plus4, 32'h4);

        // Sequential fetch.
        step(); expect_pf("seq1", 32'h4, 1'b0);
        step(); expect_pf("seq2", 32'h8, 1'b0);
        step(); expect_pf("seq3", 32'hC, 1'b0);
        step(); expect_pf("seq4", 32'h10, 1'b0);

        // Taken branch to 0x40.
        branch_sel = 1'b1; target = 32'h40;
        step(); branch_sel = 1'b0;
        expect_pf("br0", 32'h40, 1'b1);
        step(); expect_pf("br1", 32'h44, 1'b1);
        step(); expect_pf("br2", 32'h48, 1'b0);
        step(); expect_pf("br3", 32'h4C, 1'b0);

        // Jump to 0x80, stalled for 3 cycles, jumps during FLUSH ignored.
        jump = 1'b1; target = 32'h80;
        step();
        expect_pf("jmp0", 32'h80, 1'b1);
        stall = 1'b1; target = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step(); expect_pf($sformatf("stl%0d", i), 32'h80, 1'b1);
        end
        stall = 1'b0;
        step(); jump = 1'b0;
        expect_pf("jmp1", 32'h84, 1'b1);
        step(); expect_pf("jmp2", 32'h88, 1'b0);

        // Stall in RUN holds the PC.
        stall = 1'b1;
        step(); expect_pf("runstl", 32'h88, 1'b0);
        stall = 1'b0;

        // Wrap at the top of the address space.
        branch_sel = 1'b1; target = 32'hFFFF_FFF8;
        step(); branch_sel = 1'b0;
        expect_pf("wrap0", 32'hFFFF_FFF8, 1'b1);
        step(); expect_pf("wrap1", 32'hFFFF_FFFC, 1'b1);
        check("wrap.pc4", pc_plus4, 32'h0);
        step(); expect_pf("wrap2", 32'h0, 1'b0);

        // Back-to-back: redirect accepted on the first RUN edge.
        jump = 1'b1; target = 32'h300;
        step(); jump = 1'b0;
        expect_pf("b2b0", 32'h300, 1'b1);
        step(); expect_pf("b2b1", 32'h304, 1'b1);
        step(); expect_pf("b2b2", 32'h308, 1'b0);

        // Misaligned jump target.
        jump = 1'b1; target = 32'h0000_0102;
        step(); jump = 1'b0;
        expect_pf("mis0", 32'h100, 1'b1);
`ifdef MISALIGN_TRAP_EN
        check("mis0.trap", {31'd0, misalign_trap}, 32'd1);
        check("mis0.bad", bad_addr, 32'h102);
`else
        check("mis0.trap", {31'd0, misalign_trap}, 32'd0);
        check("mis0.bad", bad_addr, 32'h0);
`endif
        step(); expect_pf("mis1", 32'h104, 1'b1);
        check("mis1.trap", {31'd0, misalign_trap}, 32'd0);

        // Asynchronous reset mid-FLUSH.
        #2 rst = 1'b1;
        #1;
        expect_pf("arst", 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(); expect_pf("post1", 32'h4, 1'b0);
        step(); expect_pf("post2", 32'h8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
